gc_apb_rx_regs: RTL and testbench
=================================

Name: gc_apb_rx_regs

Overview:
- APB3 completer in the FPGA fabric, answering the MSS APB master port (MSSPSEL/MSSPENABLE/MSSPWRITE/MSSPADDR/MSSPWDATA, returning MSSPRDATA/MSSPREADY/MSSPSLVERR).
- Buffers 32-bit GameCube controller poll words, pushed by the fabric controller decoder, in a FIFO that firmware pops over APB.
- Exposes control bits (enable, rumble, irq enable) and status to firmware.
- Empty-FIFO reads stall with bounded wait states.

Parameters:
- FIFO_DEPTH, 8, number of 32-bit entries; power of 2, minimum 2.
- ADDR_W, 8, PADDR width; only bits [3:2] are decoded.
- TIMEOUT, 16, maximum wait-state cycles on an empty RXDATA read.

Ports:
- PCLK  in  1  fabric APB clock (FAB_CLK from MSS).
- PRESERN  in  1  asynchronous active-low reset (M2F_RESET_N).
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; 0 whenever PREADY=0 or not a read.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error; valid only with PREADY=1.
- rx_valid  in  1  one-cycle push strobe from decoder.
- rx_data  in  32  poll word.
- ctrl_enable  out  1  CTRL[0].
- ctrl_rumble  out  1  CTRL[1].
- irq  out  1  level interrupt.

Behaviour:
- Reset (async, PRESERN=0): all registers and outputs 0; FIFO empty; state IDLE.
- Register map (PADDR[3:2]), other bits ignored:
  - 0x00 CTRL, RW: [0] enable, [1] rumble, [2] irq_en, [3] clear. Clear self-clears and always reads 0.
  - 0x04 STATUS, RO: [0] empty, [1] full, [2] overflow (sticky; a write with PWDATA[2]=1 clears it), [15:8] count.
  - 0x08 RXDATA, RO: read pops the FIFO; writes are ignored and return PSLVERR=1.
  - 0x0C PUSHCNT, RO: 32-bit count of accepted pushes, wraps 0xFFFFFFFF->0.
  - Unmapped: none. Writes to RO registers other than the STATUS overflow clear return PSLVERR=1 and have no effect.
- State machine IDLE/RDWAIT, evaluated on cycles with PSEL=1 and PENABLE=1:
  - IDLE, any access except an RXDATA read with FIFO empty: PREADY=1 combinationally, zero wait states, PSLVERR per map. Writes commit on this edge.
  - IDLE, RXDATA read with FIFO empty: PREADY=0, go to RDWAIT, wait counter=1.
  - RDWAIT: if FIFO becomes non-empty, PREADY=1, PRDATA=head, pop, then IDLE.
  - RDWAIT: else if counter reaches TIMEOUT, PREADY=1, PSLVERR=1, PRDATA=0, then IDLE.
  - RDWAIT: else counter increments.
  - Maximum wait states = TIMEOUT.
  - PSEL dropping in RDWAIT (protocol violation): return to IDLE, no pop.
- FIFO pop: head returned combinationally in the completing access cycle; pointer advances on that edge.
- Push (rx_valid=1):
  - Not full: write at tail, count+1, PUSHCNT+1.
  - Full without a same-cycle pop: word dropped, overflow=1, PUSHCNT unchanged.
  - Full with a same-cycle pop: accepted, count unchanged.
  - Simultaneous push and pop when not full: both occur, count unchanged.
  - Push into an empty FIFO is visible to a pop on the next cycle only; no write-through.
- Clear: the write to CTRL with [3]=1 empties the FIFO on that edge and clears overflow. Clear beats a same-cycle push; the word is dropped and PUSHCNT is not incremented.
- irq = irq_en & ~empty, registered (one-cycle lag from the FIFO state change).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits, zero-extended into STATUS[15:8].

Decomposition:
- Shared package gc_apb_pkg: register offsets, CTRL/STATUS bit positions, state enum {IDLE, RDWAIT}.
- One sub-module, gc_sync_fifo (DEPTH, WIDTH=32), providing push/pop/clear/full/empty/count/overflow.
- APB decode, state machine and counters stay in gc_apb_rx_regs.

Test Plan:
- Reset, then read CTRL, STATUS, PUSHCNT -> PRDATA 0x0, 0x00000001 (empty), 0x0; PREADY=1 with 0 waits, PSLVERR=0.
- Write CTRL=0x3, then read it -> 0x3; ctrl_enable=1, ctrl_rumble=1.
- Push 0xDEAD0001..0xDEAD0003, then read RXDATA three times -> the same words in order; final STATUS=0x00000001; PUSHCNT=3.
- Empty RXDATA read with a push of 0x12345678 after 5 cycles -> PREADY low for 5 cycles, then data 0x12345678, PSLVERR=0.
- Empty RXDATA read with no push -> PREADY=0 for 16 cycles, then PREADY=1, PSLVERR=1, PRDATA=0.
- Push 9 words into depth 8 -> STATUS=0x00000806 (count 8, full, overflow). Write STATUS 0x4 -> overflow clears. Push plus pop in the same cycle while full -> count stays 8. Write CTRL[3]=1 together with a push -> empty, PUSHCNT unchanged. Set irq_en and push one word -> irq=1 one cycle later.

Source files
------------

// File: rtl/gc_apb_pkg.sv
// Shared definitions for the GameCube poll-word APB receive block:
// register offsets, CTRL/STATUS bit positions and the APB wait-state FSM encoding.
package gc_apb_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_RXDATA  = 2'd2;
  localparam logic [1:0] REG_PUSHCNT = 2'd3;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_RUMBLE_BIT = 1;
  localparam int CTRL_IRQEN_BIT  = 2;
  localparam int CTRL_CLEAR_BIT  = 3;

  localparam int STS_EMPTY_BIT = 0;
  localparam int STS_FULL_BIT  = 1;
  localparam int STS_OVF_BIT   = 2;
  localparam int STS_COUNT_LSB = 8;

  typedef enum logic {
    ST_IDLE,
    ST_RDWAIT
  } apb_state_e;

endpackage

// File: rtl/gc_sync_fifo.sv
// Single-clock FIFO with combinational head, synchronous clear and a sticky
// overflow flag set whenever a push is dropped because the FIFO is full.
module gc_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       clear,
  input  logic                       ovf_clr,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       push_accepted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             pop_eff;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign overflow = ovf_q;
  assign head     = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the same cycle pops; clear drops everything.
  assign pop_eff       = pop & ~empty & ~clear;
  assign push_accepted = push & ~clear & (~full | pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_accepted) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_eff)       rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_accepted && !pop_eff)      count_d = count_q + CW'(1);
      else if (!push_accepted && pop_eff) count_d = count_q - CW'(1);
      if (push && full && !pop_eff) ovf_d = 1'b1;
      else if (ovf_clr)             ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_accepted) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/gc_apb_rx_regs.sv
// APB3 completer exposing the controller poll-word FIFO, control bits and status;
// empty RXDATA reads stall with at most TIMEOUT wait states before erroring.
module gc_apb_rx_regs
  import gc_apb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              rx_valid,
  input  logic [31:0]       rx_data,
  output logic              ctrl_enable,
  output logic              ctrl_rumble,
  output logic              irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  apb_state_e    state_q, state_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          enable_q, enable_d;
  logic          rumble_q, rumble_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q, irq_d;
  logic [31:0]   pushcnt_q, pushcnt_d;

  logic [31:0]   fifo_head;
  logic          fifo_full, fifo_empty, fifo_ovf, fifo_push_acc;
  logic [CW-1:0] fifo_count;
  logic          fifo_pop, fifo_clear, ovf_clr;
  logic          access;
  logic [1:0]    addr;
  logic [31:0]   status_word;
  logic          unused_ok;

  assign access    = PSEL & PENABLE;
  assign addr      = PADDR[3:2];
  assign unused_ok = ^{PADDR[ADDR_W-1:4], PADDR[1:0], PWDATA[31:4]};

  gc_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk           (PCLK),
    .rst_n         (PRESERN),
    .push          (rx_valid),
    .push_data     (rx_data),
    .pop           (fifo_pop),
    .clear         (fifo_clear),
    .ovf_clr       (ovf_clr),
    .head          (fifo_head),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .count         (fifo_count),
    .overflow      (fifo_ovf),
    .push_accepted (fifo_push_acc)
  );

  always_comb begin
    status_word                                 = '0;
    status_word[STS_EMPTY_BIT]                  = fifo_empty;
    status_word[STS_FULL_BIT]                   = fifo_full;
    status_word[STS_OVF_BIT]                    = fifo_ovf;
    status_word[STS_COUNT_LSB +: 8]             = 8'(fifo_count);
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    enable_d   = enable_q;
    rumble_d   = rumble_q;
    irq_en_d   = irq_en_q;
    PRDATA     = '0;
    PREADY     = 1'b1;
    PSLVERR    = 1'b0;
    fifo_pop   = 1'b0;
    fifo_clear = 1'b0;
    ovf_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (!PWRITE && addr == REG_RXDATA && fifo_empty) begin
            PREADY  = 1'b0;
            state_d = ST_RDWAIT;
            wait_d  = TW'(1);
          end else if (PWRITE) begin
            case (addr)
              REG_CTRL: begin
                enable_d   = PWDATA[CTRL_ENABLE_BIT];
                rumble_d   = PWDATA[CTRL_RUMBLE_BIT];
                irq_en_d   = PWDATA[CTRL_IRQEN_BIT];
                fifo_clear = PWDATA[CTRL_CLEAR_BIT];
              end
              // The only legal STATUS write is one that clears overflow.
              REG_STATUS: begin
                if (PWDATA[STS_OVF_BIT]) ovf_clr = 1'b1;
                else                     PSLVERR = 1'b1;
              end
              default: PSLVERR = 1'b1;
            endcase
          end else begin
            case (addr)
              REG_CTRL:   PRDATA = {29'd0, irq_en_q, rumble_q, enable_q};
              REG_STATUS: PRDATA = status_word;
              REG_RXDATA: begin
                PRDATA   = fifo_head;
                fifo_pop = 1'b1;
              end
              default:    PRDATA = pushcnt_q;
            endcase
          end
        end
      end
      ST_RDWAIT: begin
        if (!PSEL) begin
          PREADY  = 1'b0;
          state_d = ST_IDLE;
        end else if (!fifo_empty) begin
          PRDATA   = fifo_head;
          fifo_pop = 1'b1;
          state_d  = ST_IDLE;
        end else if (wait_q == TW'(TIMEOUT)) begin
          PSLVERR = 1'b1;
          state_d = ST_IDLE;
        end else begin
          PREADY = 1'b0;
          wait_d = wait_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pushcnt_d = fifo_push_acc ? pushcnt_q + 32'd1 : pushcnt_q;
  assign irq_d     = irq_en_q & ~fifo_empty;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      enable_q  <= 1'b0;
      rumble_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      pushcnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      enable_q  <= enable_d;
      rumble_q  <= rumble_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      pushcnt_q <= pushcnt_d;
    end
  end

  assign ctrl_enable = enable_q;
  assign ctrl_rumble = rumble_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_gc_apb_rx_regs.sv
// Directed scoreboard bench: the driver queues expected APB responses, a monitor
// pops and compares them whenever the DUT completes a transfer.
module tb_gc_apb_rx_regs;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic        ctrl_enable, ctrl_rumble, irq;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          waits;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  always #5 PCLK = ~PCLK;

  gc_apb_rx_regs #(.FIFO_DEPTH(8), .ADDR_W(8), .TIMEOUT(16)) dut (
    .PCLK        (PCLK),
    .PRESERN     (PRESERN),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .ctrl_enable (ctrl_enable),
    .ctrl_rumble (ctrl_rumble),
    .irq         (irq)
  );

  // Monitor: counts wait states and checks every completed access against the queue.
  initial begin
    int   waits;
    exp_t e;
    waits = 0;
    forever begin
      @(negedge PCLK);
      if (PRESERN && PSEL && PENABLE) begin
        if (!PREADY) begin
          waits++;
        end else if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_response: PRDATA=%08h with no expected entry", PRDATA);
          waits = 0;
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (PRDATA !== e.data) begin
            miscompares++;
            $display("FAIL %s.data: got %08h, expected %08h", e.name, PRDATA, e.data);
          end
          vectors++;
          if (PSLVERR !== e.err) begin
            miscompares++;
            $display("FAIL %s.err: got %0b, expected %0b", e.name, PSLVERR, e.err);
          end
          vectors++;
          if (waits != e.waits) begin
            miscompares++;
            $display("FAIL %s.waits: got %0d, expected %0d", e.name, waits, e.waits);
          end
          $display("xfer %-14s data=%08h err=%0b waits=%0d", e.name, PRDATA, PSLVERR, waits);
          waits = 0;
        end
      end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_err, input int exp_waits,
                          input string name);
    exp_t e;
    int   n;
    e.data = exp_data; e.err = exp_err; e.waits = exp_waits; e.name = name;
    exp_q.push_back(e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!PREADY && n < 64);
    if (!PREADY) begin
      vectors++;
      miscompares++;
      $display("FAIL %s.timeout: PREADY=0 after %0d cycles, expected completion", name, n);
      void'(exp_q.pop_back());
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    @(posedge PCLK); #1;
    rx_valid = 1'b1; rx_data = d;
    @(posedge PCLK); #1;
    rx_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end else begin
      $display("check %-14s value=%08h", name, act);
    end
  endtask

  initial begin
    #3;
    check("rst_enable", 32'(ctrl_enable), 32'd0);
    check("rst_rumble", 32'(ctrl_rumble), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    #20 PRESERN = 1'b1;

    apb_xfer(1'b0, 8'h00, 0, 32'h0, 1'b0, 0, "rd_ctrl0");
    apb_xfer(1'b0, 8'h04, 0, 32'h1, 1'b0, 0, "rd_status0");
    apb_xfer(1'b0, 8'h0C, 0, 32'h0, 1'b0, 0, "rd_pushcnt0");

    apb_xfer(1'b1, 8'h00, 32'h3, 32'h0, 1'b0, 0, "wr_ctrl3");
    apb_xfer(1'b0, 8'h00, 0, 32'h3, 1'b0, 0, "rd_ctrl3");
    check("ctrl_enable", 32'(ctrl_enable), 32'd1);
    check("ctrl_rumble", 32'(ctrl_rumble), 32'd1);

    push_word(32'hDEAD0001);
    push_word(32'hDEAD0002);
    push_word(32'hDEAD0003);
    apb_xfer(1'b0, 8'h04, 0, 32'h0000_0300, 1'b0, 0, "rd_status3");
    apb_xfer(1'b0, 8'h08, 0, 32'hDEAD0001, 1'b0, 0, "rd_rx1");
    apb_xfer(1'b0, 8'h08, 0, 32'hDEAD0002, 1'b0, 0, "rd_rx2");
    apb_xfer(1'b0, 8'h08, 0, 32'hDEAD0003, 1'b0, 0, "rd_rx3");
    apb_xfer(1'b0, 8'h04, 0, 32'h1, 1'b0, 0, "rd_status_e");
    apb_xfer(1'b0, 8'h0C, 0, 32'd3, 1'b0, 0, "rd_pushcnt3");

    // Push lands during wait cycle 4; data returns on cycle 5.
    fork
      apb_xfer(1'b0, 8'h08, 0, 32'h12345678, 1'b0, 5, "rd_rx_stall");
      begin
        repeat (6) @(posedge PCLK);
        #1 rx_valid = 1'b1; rx_data = 32'h12345678;
        @(posedge PCLK);
        #1 rx_valid = 1'b0;
      end
    join

    apb_xfer(1'b0, 8'h08, 0, 32'h0, 1'b1, 16, "rd_rx_timeout");

    apb_xfer(1'b1, 8'h08, 32'h1, 32'h0, 1'b1, 0, "wr_rxdata");
    apb_xfer(1'b1, 8'h0C, 32'h1, 32'h0, 1'b1, 0, "wr_pushcnt");
    apb_xfer(1'b1, 8'h04, 32'h0, 32'h0, 1'b1, 0, "wr_status0");

    for (int i = 0; i < 9; i++) push_word(32'hA000_0000 + 32'(i));
    apb_xfer(1'b0, 8'h04, 0, 32'h0000_0806, 1'b0, 0, "rd_status_ovf");
    apb_xfer(1'b1, 8'h04, 32'h4, 32'h0, 1'b0, 0, "wr_status_clr");
    apb_xfer(1'b0, 8'h04, 0, 32'h0000_0802, 1'b0, 0, "rd_status_full");

    fork
      apb_xfer(1'b0, 8'h08, 0, 32'hA000_0000, 1'b0, 0, "rd_rx_fullpp");
      begin
        repeat (2) @(posedge PCLK);
        #1 rx_valid = 1'b1; rx_data = 32'hB000_0000;
        @(posedge PCLK);
        #1 rx_valid = 1'b0;
      end
    join
    apb_xfer(1'b0, 8'h04, 0, 32'h0000_0802, 1'b0, 0, "rd_status_pp");
    apb_xfer(1'b0, 8'h0C, 0, 32'd13, 1'b0, 0, "rd_pushcnt13");

    fork
      apb_xfer(1'b1, 8'h00, 32'h8, 32'h0, 1'b0, 0, "wr_ctrl_clr");
      begin
        repeat (2) @(posedge PCLK);
        #1 rx_valid = 1'b1; rx_data = 32'hC000_0000;
        @(posedge PCLK);
        #1 rx_valid = 1'b0;
      end
    join
    apb_xfer(1'b0, 8'h04, 0, 32'h1, 1'b0, 0, "rd_status_clr");
    apb_xfer(1'b0, 8'h0C, 0, 32'd13, 1'b0, 0, "rd_pushcnt_clr");
    check("enable_cleared", 32'(ctrl_enable), 32'd0);

    apb_xfer(1'b1, 8'h00, 32'h4, 32'h0, 1'b0, 0, "wr_ctrl_irqen");
    apb_xfer(1'b0, 8'h00, 0, 32'h4, 1'b0, 0, "rd_ctrl_irqen");
    check("irq_idle", 32'(irq), 32'd0);
    push_word(32'hD000_0000);
    check("irq_lag", 32'(irq), 32'd0);
    @(posedge PCLK); #1;
    check("irq_set", 32'(irq), 32'd1);
    apb_xfer(1'b0, 8'h08, 0, 32'hD000_0000, 1'b0, 0, "rd_rx_irq");
    apb_xfer(1'b0, 8'h0C, 0, 32'd14, 1'b0, 0, "rd_pushcnt14");

    repeat (3) @(posedge PCLK);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
